// File: rtl/imm_decode_pipe_if.sv
// Handshake bundle for imm_decode_pipe: input side (instruction + PC),
// output side (decoded immediate, format tag, illegal flag, pass-throughs)
// and the synchronous flush. The slave modport is the stage's view; the
// master modport is the view of whatever drives and consumes the stage.
interface imm_decode_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_pc
    );
endinterface

// File: rtl/imm_decode_pipe.sv
// Registered RV32I/RV64I immediate-generation stage with a 2-entry skid
// buffer. Decode happens on the input side; the decoded result travels
// with the instruction and PC. All outputs come straight from the head
// entry register, and in_ready is a decode of the occupancy state only.
// Optional feature: define IMM_ZICSR_EN to decode the SYSTEM opcode.
module imm_decode_pipe #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    imm_decode_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
`ifdef IMM_ZICSR_EN
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
`endif

    // Sign-extend a 32-bit immediate image to XLEN (a size cast of a signed
    // value replicates the sign bit).
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    state_e          r_state;
    state_e          w_state_nxt;
    entry_t          r_head;
    entry_t          r_skid;
    entry_t          w_new;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_head_in;
    logic            w_load_head_skid;
    logic            w_load_skid;

    logic [31:0]     w_inst;
    logic [2:0]      w_f3;
    logic            w_is_shift;
    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_ill;

    assign w_inst     = bus.in_inst;
    assign w_f3       = w_inst[14:12];
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // Combinational immediate decode of the incoming instruction word.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_imm = '0;
        w_fmt = FMT_NONE;
        w_ill = 1'b0;
        if (w_inst[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_inst[6:0])
                OPC_LOAD, OPC_JALR: begin
                    w_fmt = FMT_I;
                    w_imm = sext32({{20{w_inst[31]}}, w_inst[31:20]});
                end
                OPC_OP_IMM: begin
                    if (!w_is_shift) begin
                        w_fmt = FMT_I;
                        w_imm = sext32({{20{w_inst[31]}}, w_inst[31:20]});
                    end else if (XLEN == 64) begin
                        w_fmt = FMT_SH;
                        w_imm = XLEN'(w_inst[25:20]);
                    end else if (w_inst[25]) begin
                        w_ill = 1'b1;
                    end else begin
                        w_fmt = FMT_SH;
                        w_imm = XLEN'(w_inst[24:20]);
                    end
                end
                OPC_OP_IMM32: begin
                    if (XLEN != 64) begin
                        w_ill = 1'b1;
                    end else if (w_is_shift) begin
                        w_fmt = FMT_SH;
                        w_imm = XLEN'(w_inst[24:20]);
                    end else begin
                        w_fmt = FMT_I;
                        w_imm = sext32({{20{w_inst[31]}}, w_inst[31:20]});
                    end
                end
                OPC_STORE: begin
                    w_fmt = FMT_S;
                    w_imm = sext32({{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]});
                end
                OPC_BRANCH: begin
                    w_fmt = FMT_B;
                    w_imm = sext32({{19{w_inst[31]}}, w_inst[31], w_inst[7],
                                    w_inst[30:25], w_inst[11:8], 1'b0});
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_fmt = FMT_U;
                    w_imm = sext32({w_inst[31:12], 12'b0});
                end
                OPC_JAL: begin
                    w_fmt = FMT_J;
                    w_imm = sext32({{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                                    w_inst[20], w_inst[30:21], 1'b0});
                end
                OPC_OP: begin
                    w_fmt = FMT_NONE;
                end
                OPC_OP32: begin
                    w_ill = (XLEN != 64);
                end
`ifdef IMM_ZICSR_EN
                OPC_SYSTEM: begin
                    case (w_f3)
                        3'b101, 3'b110, 3'b111: begin
                            w_fmt = FMT_Z;
                            w_imm = XLEN'(w_inst[19:15]);
                        end
                        3'b001, 3'b010, 3'b011: begin
                            w_fmt = FMT_I;
                            w_imm = XLEN'(w_inst[31:20]);
                        end
                        3'b000:  w_fmt = FMT_NONE;
                        default: w_ill = 1'b1;
                    endcase
                end
`endif
                default: w_ill = 1'b1;
            endcase
        end
        // Illegal encodings always report a zero immediate and NONE format.
        if (w_ill) begin
            w_imm = '0;
            w_fmt = FMT_NONE;
        end
    end

    assign w_new.imm     = w_imm;
    assign w_new.fmt     = w_fmt;
    assign w_new.illegal = w_ill;
    assign w_new.inst    = w_inst;
    assign w_new.pc      = bus.in_pc;

    assign bus.in_ready  = (r_state != TWO);
    assign bus.out_valid = (r_state != EMPTY);
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_drain       = bus.out_valid & bus.out_ready;

    // Occupancy state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    // Next occupancy and which entry register loads; flush wins over all.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_load_head_in = 1'b1;
                        w_state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_head_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = TWO;
                    end else if (w_drain) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_drain) begin
                        w_load_head_skid = 1'b1;
                        w_state_nxt      = ONE;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Head (output) and skid entry registers; the head changes only on a
    // load, so output fields hold while stalled.
    // NOTE: both entries are reset because the outputs are driven directly
    // from the head entry and must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in)        r_head <= w_new;
            else if (w_load_head_skid) r_head <= r_skid;
            if (w_load_skid)           r_skid <= w_new;
        end
    end

    assign bus.out_imm     = r_head.imm;
    assign bus.out_fmt     = r_head.fmt;
    assign bus.out_illegal = r_head.illegal;
    assign bus.out_inst    = r_head.inst;
    assign bus.out_pc      = r_head.pc;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Self-checking bench for imm_decode_pipe. An XLEN=32 and an XLEN=64
// instance receive identical stimulus; a queue-based reference model
// predicts occupancy, ordering and the decoded fields of both.
module tb_imm_decode_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_decode_pipe_if #(.XLEN(32)) if32 ();
    imm_decode_pipe_if #(.XLEN(64)) if64 ();

    imm_decode_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    imm_decode_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode computed with plain signed arithmetic on the word.
    function automatic void ref_decode(input logic [31:0] inst, input bit x64,
                                       output logic [63:0] imm, output logic [2:0] fmt,
                                       output logic ill);
        longint v = 0;
        logic [2:0] f3 = inst[14:12];
        bit sh = (f3 == 3'd1) || (f3 == 3'd5);
        longint s = longint'($signed(inst));
        fmt = 3'd0;
        ill = 1'b0;
        if (inst[1:0] != 2'b11) ill = 1'b1;
        else begin
            case (inst[6:0])
                7'h03, 7'h67: begin fmt = 1; v = s >>> 20; end
                7'h13: begin
                    if (!sh) begin fmt = 1; v = s >>> 20; end
                    else if (x64) begin fmt = 6; v = longint'(inst[25:20]); end
                    else if (inst[25]) ill = 1'b1;
                    else begin fmt = 6; v = longint'(inst[24:20]); end
                end
                7'h1B: begin
                    if (!x64) ill = 1'b1;
                    else if (sh) begin fmt = 6; v = longint'(inst[24:20]); end
                    else begin fmt = 1; v = s >>> 20; end
                end
                7'h23: begin fmt = 2; v = ((s >>> 25) * 32) + longint'(inst[11:7]); end
                7'h63: begin
                    fmt = 3;
                    v = (inst[31] ? -64'sd4096 : 64'sd0) + longint'(inst[7]) * 2048
                        + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                end
                7'h37, 7'h17: begin fmt = 4; v = longint'($signed(inst & 32'hFFFF_F000)); end
                7'h6F: begin
                    fmt = 5;
                    v = (inst[31] ? -64'sd1048576 : 64'sd0) + longint'(inst[19:12]) * 4096
                        + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                end
                7'h33: fmt = 0;
                7'h3B: ill = !x64;
`ifdef IMM_ZICSR_EN
                7'h73: begin
                    if (f3 >= 5) begin fmt = 7; v = longint'(inst[19:15]); end
                    else if (f3 >= 1 && f3 <= 3) begin fmt = 1; v = longint'(inst[31:20]); end
                    else if (f3 == 4) ill = 1'b1;
                end
`endif
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin fmt = 0; v = 0; end
        imm = x64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    endfunction

    // Compare both instances against the model's predicted head entry.
    task automatic check_outputs();
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        check("rdy32", if32.in_ready, q.size() < 2);
        check("rdy64", if64.in_ready, q.size() < 2);
        check("vld32", if32.out_valid, q.size() != 0);
        check("vld64", if64.out_valid, q.size() != 0);
        if (q.size() != 0) begin
            ref_decode(q[0].inst, 1'b0, imm, fmt, ill);
            check("imm32", if32.out_imm, imm);
            check("fmt32", if32.out_fmt, fmt);
            check("ill32", if32.out_illegal, ill);
            check("inst32", if32.out_inst, q[0].inst);
            check("pc32", if32.out_pc, q[0].pc & 64'hFFFF_FFFF);
            ref_decode(q[0].inst, 1'b1, imm, fmt, ill);
            check("imm64", if64.out_imm, imm);
            check("fmt64", if64.out_fmt, fmt);
            check("ill64", if64.out_illegal, ill);
            check("inst64", if64.out_inst, q[0].inst);
            check("pc64", if64.out_pc, q[0].pc);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        if32.in_valid = v;   if64.in_valid = v;
        if32.in_inst = inst; if64.in_inst = inst;
        if32.in_pc = pc[31:0]; if64.in_pc = pc;
        if32.out_ready = rdy; if64.out_ready = rdy;
        if32.flush = fl;     if64.flush = fl;
    endtask

    // One cycle: drive at the negedge, update the model at the posedge,
    // check at the following negedge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic rdy, input logic fl);
        bit acc, drn;
        ent_t e;
        drive(v, inst, pc, rdy, fl);
        acc = v && (q.size() < 2);
        drn = (q.size() != 0) && rdy;
        e.inst = inst;
        e.pc   = pc;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [13] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h73, 7'h00};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 12);
        if (k != 12) w[6:0] = ops[k];
        if ($urandom_range(0, 7) != 0 && k != 12) w[1:0] = 2'b11;
        return w;
    endfunction

    function automatic logic [63:0] rand_pc();
        return {$urandom, $urandom};
    endfunction

    initial begin
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_vld", if32.out_valid, 1'b0);
        check("rst_rdy", if32.in_ready, 1'b1);
        check("rst_imm", if64.out_imm, 64'h0);
        check("rst_inst", if32.out_inst, 32'h0);
        check("rst_pc", if64.out_pc, 64'h0);
        check("rst_fmt_ill", {if32.out_fmt, if32.out_illegal}, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        check_outputs();

        // jal with only the sign bit of the offset set.
        step(1'b1, 32'h8000_00EF, 64'h1000, 1'b1, 1'b0);
        check("jal_imm32", if32.out_imm, 32'hFFF0_0000);
        check("jal_fmt", if32.out_fmt, 3'd5);
        check("jal_ill", if32.out_illegal, 1'b0);
        check("jal_imm64", if64.out_imm, 64'hFFFF_FFFF_FFF0_0000);

        // srai by 63: legal shamt on RV64, illegal on RV32.
        step(1'b1, 32'h43F0_D093, 64'h1004, 1'b1, 1'b0);
        check("srai_imm64", if64.out_imm, 64'h3F);
        check("srai_fmt64", if64.out_fmt, 3'd6);
        check("srai_ill32", if32.out_illegal, 1'b1);
        check("srai_imm32", if32.out_imm, 64'h0);

        // csrrwi x0, mscratch, 15.
        step(1'b1, 32'h3407_D073, 64'h1008, 1'b1, 1'b0);
`ifdef IMM_ZICSR_EN
        check("csr_imm", if32.out_imm, 32'h0F);
        check("csr_fmt", if32.out_fmt, 3'd7);
`else
        check("csr_ill", if32.out_illegal, 1'b1);
        check("csr_imm", if32.out_imm, 32'h0);
`endif
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Backpressure: three back-to-back pushes while stalled.
        step(1'b1, 32'h0010_0093, 64'h2000, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0113, 64'h2004, 1'b0, 1'b0);
        check("bp_rdy_low", if32.in_ready, 1'b0);
        check("bp_frozen", if32.out_inst, 32'h0010_0093);
        step(1'b1, 32'h0030_0193, 64'h2008, 1'b0, 1'b0);
        check("bp_still", if64.out_inst, 32'h0010_0093);
        step(1'b1, 32'h0030_0193, 64'h2008, 1'b1, 1'b0);
        check("bp_2nd", if32.out_inst, 32'h0020_0113);
        step(1'b1, 32'h0030_0193, 64'h2008, 1'b1, 1'b0);
        check("bp_3rd", if32.out_inst, 32'h0030_0193);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Flush at occupancy 2 with a same-cycle input.
        step(1'b1, 32'h0000_0537, 64'h3000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0597, 64'h3004, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0613, 64'h3008, 1'b0, 1'b1);
        check("fl_vld", if32.out_valid, 1'b0);
        check("fl_rdy", if64.in_ready, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), rand_pc(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
        end

        // Asynchronous reset while two entries are buffered.
        step(1'b1, 32'hFFF0_0067, 64'h4000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_006F, 64'h4004, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_vld", if32.out_valid, 1'b0);
        check("ar_vld64", if64.out_valid, 1'b0);
        check("ar_rdy", if32.in_ready, 1'b1);
        check("ar_imm", if32.out_imm, 32'h0);
        check("ar_inst", if64.out_inst, 32'h0);
        check("ar_pc", if64.out_pc, 64'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check("ar_nothing", if32.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
